// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register for the 5-stage MIPS core.
// Handles freeze, load-use bubble, branch flush and a saturating bubble counter.
module id_exe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CMD_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              bubble,
    input  logic              flush,
    input  logic              ID_valid,
    input  logic [DATA_W-1:0] ID_PC,
    input  logic [CMD_W-1:0]  ID_EXE_CMD,
    input  logic              ID_MEM_R_EN,
    input  logic              ID_MEM_W_EN,
    input  logic              ID_WB_EN,
    input  logic              ID_B,
    input  logic              ID_Imm,
    input  logic [DATA_W-1:0] ID_Val1,
    input  logic [DATA_W-1:0] ID_Val2,
    input  logic [DATA_W-1:0] ID_ST_val,
    input  logic [REG_W-1:0]  ID_src1,
    input  logic [REG_W-1:0]  ID_src2,
    input  logic [REG_W-1:0]  ID_ST_src,
    input  logic [REG_W-1:0]  ID_Dest,
    output logic              EXE_valid,
    output logic [DATA_W-1:0] EXE_PC,
    output logic [CMD_W-1:0]  EXE_EXE_CMD,
    output logic              EXE_MEM_R_EN,
    output logic              EXE_MEM_W_EN,
    output logic              EXE_WB_EN,
    output logic              EXE_B,
    output logic              EXE_Imm,
    output logic [DATA_W-1:0] EXE_Val1,
    output logic [DATA_W-1:0] EXE_Val2,
    output logic [DATA_W-1:0] EXE_ST_val,
    output logic [REG_W-1:0]  EXE_src1,
    output logic [REG_W-1:0]  EXE_src2,
    output logic [REG_W-1:0]  EXE_ST_src,
    output logic [REG_W-1:0]  EXE_Dest,
    output logic [15:0]       bubble_count
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [CMD_W-1:0]  cmd;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              wb_en;
        logic              b;
        logic              imm;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] st_val;
        logic [REG_W-1:0]  src1;
        logic [REG_W-1:0]  src2;
        logic [REG_W-1:0]  st_src;
        logic [REG_W-1:0]  dest;
    } stage_t;

    stage_t      stage_q;
    stage_t      stage_d;
    logic [15:0] count_q;
    logic        load_nop;

    // Flush beats freeze; a bubble only takes effect when the stage is not frozen.
    assign load_nop = flush | (~freeze & bubble);

    always_comb begin
        stage_d          = '0;
        stage_d.valid    = ID_valid;
        stage_d.pc       = ID_PC;
        stage_d.cmd      = ID_EXE_CMD;
        stage_d.mem_r_en = ID_MEM_R_EN & ID_valid;
        stage_d.mem_w_en = ID_MEM_W_EN & ID_valid;
        stage_d.wb_en    = ID_WB_EN & ID_valid;
        stage_d.b        = ID_B & ID_valid;
        stage_d.imm      = ID_Imm;
        stage_d.val1     = ID_Val1;
        stage_d.val2     = ID_Val2;
        stage_d.st_val   = ID_ST_val;
        stage_d.src1     = ID_src1;
        stage_d.src2     = ID_src2;
        stage_d.st_src   = ID_ST_src;
        stage_d.dest     = ID_Dest;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
            count_q <= '0;
        end else if (load_nop) begin
            stage_q <= '0;
            if (count_q != '1) begin
                count_q <= count_q + 16'd1;
            end
        end else if (!freeze) begin
            stage_q <= stage_d;
        end
    end

    assign EXE_valid    = stage_q.valid;
    assign EXE_PC       = stage_q.pc;
    assign EXE_EXE_CMD  = stage_q.cmd;
    assign EXE_MEM_R_EN = stage_q.mem_r_en;
    assign EXE_MEM_W_EN = stage_q.mem_w_en;
    assign EXE_WB_EN    = stage_q.wb_en;
    assign EXE_B        = stage_q.b;
    assign EXE_Imm      = stage_q.imm;
    assign EXE_Val1     = stage_q.val1;
    assign EXE_Val2     = stage_q.val2;
    assign EXE_ST_val   = stage_q.st_val;
    assign EXE_src1     = stage_q.src1;
    assign EXE_src2     = stage_q.src2;
    assign EXE_ST_src   = stage_q.st_src;
    assign EXE_Dest     = stage_q.dest;
    assign bubble_count = count_q;

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
ID/EXE pipeline register of the 5-stage MIPS core. It captures the decoded instruction, operand values and register specifiers at the end of ID. It presents them to EXE, where the forwarding unit consumes src1/src2/ST_src and the EXE operand muxes consume Val1/Val2/ST_val. The block implements the stall (freeze), hazard bubble and branch flush behaviour of the ID/EXE boundary.

Parameters:
DATA_W, 32, width of operand values and PC
REG_W, 5, register specifier width
CMD_W, 4, ALU command width; all-zero is the NOP command

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
freeze  in  1  hold all stored fields (memory/cache stall)
bubble  in  1  load-use hazard; insert a NOP instead of the ID instruction
flush  in  1  taken branch in EXE; kill the ID instruction
ID_valid  in  1  ID holds a real instruction
ID_PC  in  DATA_W  PC+4 of the ID instruction
ID_EXE_CMD  in  CMD_W  ALU command
ID_MEM_R_EN  in  1  load
ID_MEM_W_EN  in  1  store
ID_WB_EN  in  1  register write-back
ID_B  in  1  branch instruction
ID_Imm  in  1  Val2 is an immediate
ID_Val1  in  DATA_W  register-file read of src1
ID_Val2  in  DATA_W  register-file read of src2 or sign-extended immediate
ID_ST_val  in  DATA_W  register-file read of store-data register
ID_src1  in  REG_W  first source specifier
ID_src2  in  REG_W  second source specifier; 0 when Imm
ID_ST_src  in  REG_W  store-data specifier
ID_Dest  in  REG_W  destination specifier
EXE_valid  out  1  EXE holds a real instruction
EXE_PC, EXE_EXE_CMD, EXE_MEM_R_EN, EXE_MEM_W_EN, EXE_WB_EN, EXE_B, EXE_Imm, EXE_Val1, EXE_Val2, EXE_ST_val, EXE_src1, EXE_src2, EXE_ST_src, EXE_Dest  out  (widths as ID_ counterparts)  registered copies
bubble_count  out  16  saturating count of bubbles and flushes inserted since reset (performance counter)

Behaviour:
- All outputs are registered. Latency is 1 cycle from the ID_ inputs to the EXE_ outputs. There is no combinational path from any input to any output.
- Reset: when rst_n=0 at a rising edge, every output goes to 0, including bubble_count. Reset overrides all other inputs. Reset mid-stall discards the held instruction.
- Per-edge priority when rst_n=1:
  - 1. flush=1: load a NOP, regardless of freeze or bubble.
  - 2. Else freeze=1: hold every output, including bubble_count. A bubble asserted during freeze is ignored; the hazard unit re-asserts it.
  - 3. Else bubble=1: load a NOP.
  - 4. Else: load all ID_ fields. EXE_valid <= ID_valid.
- NOP definition:
  - Zero these fields: EXE_valid, EXE_EXE_CMD, EXE_MEM_R_EN, EXE_MEM_W_EN, EXE_WB_EN, EXE_B, EXE_Imm, EXE_src1, EXE_src2, EXE_ST_src, EXE_Dest.
  - EXE_Val1, EXE_Val2, EXE_ST_val and EXE_PC are also 0.
  - Zeroed specifiers make the forwarding unit select the register-0 path, so a NOP never forwards or writes.
- Loading an instruction with ID_valid=0 is equivalent to a NOP for the control fields (WB_EN, MEM_R_EN, MEM_W_EN, B forced 0). Data and specifier fields are still loaded. bubble_count does not increment in this case.
- bubble_count increments by 1 on every edge that takes priority 1 or 3. It saturates at 16'hFFFF and does not wrap.
- Simultaneous flush and bubble count once.
- Value conventions:
  - Specifier fields are passed unmodified; register 0 is legal and carries no special handling here.
  - EXE_Imm=1 with EXE_src2=0 is legal and is the normal immediate form.

Test Plan:
- Reset: rst_n=0 for 2 cycles with ID inputs nonzero -> all outputs 0, bubble_count=0. Release -> next edge loads ID_PC=32'h10, ID_WB_EN=1, ID_Dest=5'd3 unchanged.
- Normal flow: 4 back-to-back instructions (src1=1..4, Dest=5..8) -> each appears on EXE_ exactly 1 cycle later, in order, with EXE_valid=1.
- Freeze: freeze=1 for 3 cycles while ID changes each cycle -> EXE_ outputs stay at the pre-freeze instruction. The instruction present when freeze drops is loaded on the next edge.
- Bubble: ID load with src1=Dest of the EXE load, bubble=1 for 1 cycle -> EXE shows NOP (WB_EN=0, src1=src2=ST_src=0, valid=0), bubble_count=1. The next edge loads the held ID instruction.
- Flush vs freeze/bubble: flush=1 with freeze=1 and bubble=1 on the same edge -> NOP loaded, bubble_count increments by exactly 1.
- Saturation: apply 65537 consecutive bubbles -> bubble_count=16'hFFFF. Reset mid-run -> 0 on the next edge, and freeze held across the reset has no effect.
